// File: rtl/demux_one_to_two_pkg.sv
// Shared constants and helpers for the 1-to-2 stream demultiplexer.
package demux_one_to_two_pkg;

   localparam logic CH_A     = 1'b0;
   localparam logic CH_B     = 1'b1;
   localparam logic MODE_ALT = 1'b0;
   localparam logic MODE_SEL = 1'b1;

   function automatic int ptr_w(input int depth);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < depth)
            w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/demux_one_to_two_fifo.sv
// Per-channel FIFO; head holds the last popped beat while empty.
module chan_fifo
   import demux_one_to_two_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW:0]   CAP = (PW+1)'(DEPTH);
   localparam logic [PW:0]   C1  = (PW+1)'(1);
   localparam logic [PW-1:0] P1  = PW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW:0]      count;
   logic [WIDTH-1:0] hold;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CAP);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? hold : mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         hold  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + P1;
         end
         if (do_pop) begin
            hold <= mem[rptr];
            rptr <= rptr + P1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + C1;
            2'b01:   count <= count - C1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/demux_one_to_two.sv
// Steers one valid/ready stream into two buffered channels,
// by explicit select or by alternating A/B.
module demux_one_to_two
   import demux_one_to_two_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             slot
);

   logic tgt;
   logic acc;
   logic a_push;
   logic b_push;
   logic a_full;
   logic a_empty;
   logic b_full;
   logic b_empty;

   assign tgt      = (mode == MODE_SEL) ? in_sel : slot;
   // Readiness depends only on the target's fullness, never on consumer ready.
   assign in_ready = (tgt == CH_B) ? ~b_full : ~a_full;
   assign acc      = in_valid & in_ready;
   assign a_push   = acc & (tgt == CH_A);
   assign b_push   = acc & (tgt == CH_B);
   assign a_valid  = ~a_empty;
   assign b_valid  = ~b_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot <= CH_A;
      else if (acc && mode == MODE_ALT)
         slot <= ~slot;
   end

   chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (a_push),
      .push_data (in_data),
      .pop       (a_ready & a_valid),
      .full      (a_full),
      .empty     (a_empty),
      .head      (a_data)
   );

   chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (b_push),
      .push_data (in_data),
      .pop       (b_ready & b_valid),
      .full      (b_full),
      .empty     (b_empty),
      .head      (b_data)
   );

endmodule

// File: tb/tb_demux_one_to_two.sv
// Scoreboard bench: stimulus predicts per-channel queues, monitor pops and compares.
module tb_demux_one_to_two;

   localparam int WIDTH = 4;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mode = 1'b0;
   logic             in_sel = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             a_valid;
   logic             a_ready = 1'b0;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready = 1'b0;
   logic [WIDTH-1:0] b_data;
   logic             slot;

   demux_one_to_two #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .slot     (slot)
   );

   always #5 clk = ~clk;

   // Reference model: visible contents of each channel, alternation slot,
   // last value shown by each empty channel.
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic             mslot = 1'b0;
   logic             nslot = 1'b0;
   logic             exp_ready = 1'b1;
   logic [WIDTH-1:0] lasta = '0;
   logic [WIDTH-1:0] lastb = '0;
   logic             pv = 1'b0;
   logic             ptgt = 1'b0;
   logic [WIDTH-1:0] pd = '0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One cycle of stimulus, applied just after the rising edge.
   task automatic step(input logic v, input logic m, input logic s,
                       input logic [WIDTH-1:0] d,
                       input logic ar, input logic br);
      logic t;
      @(posedge clk);
      #1;
      if (pv) begin
         if (ptgt) qb.push_back(pd);
         else      qa.push_back(pd);
      end
      pv       = 1'b0;
      mslot    = nslot;
      rst_n    = 1'b1;
      in_valid = v;
      mode     = m;
      in_sel   = s;
      in_data  = d;
      a_ready  = ar;
      b_ready  = br;
      t = m ? s : mslot;
      exp_ready = t ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      if (v && exp_ready) begin
         pv   = 1'b1;
         ptgt = t;
         pd   = d;
         if (!m) nslot = ~mslot;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      qa.delete();
      qb.delete();
      pv        = 1'b0;
      mslot     = 1'b0;
      nslot     = 1'b0;
      lasta     = '0;
      lastb     = '0;
      exp_ready = 1'b1;
   endtask

   // Monitor: outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_a_valid", 32'(a_valid), 32'd0);
         chk("rst_b_valid", 32'(b_valid), 32'd0);
         chk("rst_a_data", 32'(a_data), 32'd0);
         chk("rst_b_data", 32'(b_data), 32'd0);
         chk("rst_slot", 32'(slot), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
      end else begin
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("slot", 32'(slot), 32'(mslot));
         chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
         chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
         if (qa.size() != 0) begin
            chk("a_data", 32'(a_data), 32'(qa[0]));
            if (a_ready) lasta = qa.pop_front();
         end else begin
            chk("a_hold", 32'(a_data), 32'(lasta));
         end
         if (qb.size() != 0) begin
            chk("b_data", 32'(b_data), 32'(qb[0]));
            if (b_ready) lastb = qb.pop_front();
         end else begin
            chk("b_hold", 32'(b_data), 32'(lastb));
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 0, 0);

      // mid-stream reset
      step(1, 0, 0, 4'd1, 0, 0);
      step(1, 0, 0, 4'd2, 0, 0);
      step(1, 0, 0, 4'd3, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0);

      // alternate deinterleave
      for (int i = 1; i <= 6; i++)
         step(1, 0, 0, 4'(i), 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);

      // backpressure on A, retarget to B, then drain A
      step(1, 1, 0, 4'd7, 0, 1);
      step(1, 1, 0, 4'd8, 0, 1);
      step(1, 1, 0, 4'd9, 0, 1);
      step(1, 1, 0, 4'd9, 0, 1);
      step(1, 1, 1, 4'd9, 0, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);

      // full A with simultaneous pop: push blocked, then accepted
      step(1, 1, 0, 4'd1, 0, 1);
      step(1, 1, 0, 4'd2, 0, 1);
      step(1, 1, 0, 4'd3, 1, 1);
      step(1, 1, 0, 4'd3, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);

      // pointer wrap through B
      for (int i = 0; i < 10; i++)
         step(1, 1, 1, 4'(i), 1, 1);
      step(0, 1, 1, 0, 1, 1);
      step(0, 1, 1, 0, 1, 1);

      // mode switch keeps slot
      do_reset();
      step(1, 0, 0, 4'd5, 1, 1);
      step(1, 1, 0, 4'd6, 1, 1);
      step(1, 1, 0, 4'd7, 1, 1);
      step(1, 0, 0, 4'd8, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      for (int i = 0; i < 6; i++)
         step(0, 0, 0, 0, 1, 1);
      @(posedge clk);
      #1;
      chk("drain_a", 32'(qa.size()), 32'd0);
      chk("drain_b", 32'(qb.size()), 32'd0);
      chk("drain_pending", 32'(pv), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
